ram_param: RTL and testbench

RAM_PARAM -- requirements
Module: ram_param

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_param_if.sv | 31 +++
 rtl/ram_clear_fsm.sv | 43 ++++
 rtl/ram_param.sv | 79 +++++++
 tb/tb_ram_param.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the parameterised RAM: default geometry and the
// clear-sweep FSM state type.
package ram_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 64;

    // CLEAR runs the post-reset zero sweep; IDLE serves reads and writes.
    typedef enum logic [0:0] {
        ST_CLEAR,
        ST_IDLE
    } state_e;

endpackage

// File: rtl/ram_param_if.sv
// Access bus of the parameterised RAM. The master drives enable, strobes,
// address and write data; the slave returns read data, VALID and BUSY.
interface ram_param_if
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) ();

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              e;
    logic              w;
    logic              r;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  d;
    logic [WIDTH-1:0]  out;
    logic              valid;
    logic              busy;

    modport master (
        output e, w, r, addr, d,
        input  out, valid, busy
    );

    modport slave (
        input  e, w, r, addr, d,
        output out, valid, busy
    );

endinterface

// File: rtl/ram_clear_fsm.sv
// Post-reset clear sequencer: owns the CLEAR/IDLE state, the sweep pointer
// and BUSY. One address is cleared per cycle, 0 up to DEPTH-1, so the sweep
// lasts exactly DEPTH cycles after reset release.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    output state_e                   state,
    output logic [$clog2(DEPTH)-1:0] ptr,
    output logic                     busy
);

    localparam int unsigned       ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    // Sweep state, pointer and BUSY; reset restarts the sweep from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    // Pointer wraps back to 0 on the last address.
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    ptr  <= '0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_param.sv
// Parameterised single-port RAM with a post-reset zero sweep and a
// registered read port (1-cycle latency, one-cycle VALID pulse).
// Optional build macro RAM_PARAM_FWD_EN: a same-address read and write in
// one cycle returns the new write data instead of the old stored word.
module ram_param
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    ram_param_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic              busy;
    logic              idle;
    logic              wr_en;
    logic              rd_en;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  rd_q;
    logic              valid_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    ram_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk   (clk),
        .rst   (rst),
        .state (state),
        .ptr   (ptr),
        .busy  (busy)
    );

    // Accesses are only accepted once the clear sweep has finished.
    assign idle  = (state == ST_IDLE);
    assign wr_en = idle & bus.e & bus.w;
    assign rd_en = idle & bus.e & bus.r;

`ifdef RAM_PARAM_FWD_EN
    // Read and write share the address, so a concurrent write always collides.
    assign rd_data = wr_en ? bus.d : mem[bus.addr];
`else
    assign rd_data = mem[bus.addr];
`endif

    // Storage: sweep clears one word per cycle; IDLE writes take D; reset aborts both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_en) begin
                mem[bus.addr] <= bus.d;
            end
        end
    end

    // Read register and VALID pulse; OUT holds when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                rd_q <= rd_data;
            end
        end
    end

    assign bus.out   = rd_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy;

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: a 16x64 instance and an 8x256 instance.
// Expected read data is queued when a read is issued and compared when
// VALID appears; sampling happens on the falling clock edge.
module tb_ram_param;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ram_param_if #(.WIDTH(16), .DEPTH(64))  a_if ();
    ram_param_if #(.WIDTH(8),  .DEPTH(256)) b_if ();

    ram_param #(.WIDTH(16), .DEPTH(64)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    ram_param #(.WIDTH(8), .DEPTH(256)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    int          total = 0;
    int          bad   = 0;
    int          run_a = 0;
    int          run_b = 0;
    int          cnt;
    logic [15:0] qa [$];
    logic [7:0]  qb [$];
    logic [15:0] collide_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any VALID from either DUT.
    task automatic tick();
        @(negedge clk);
        if (a_if.valid === 1'b1) begin
            run_a++;
            if (qa.size() == 0) chk("a_unexpected_valid", a_if.valid, 0);
            else chk("a_read_data", a_if.out, qa.pop_front());
        end else begin
            run_a = 0;
        end
        if (b_if.valid === 1'b1) begin
            run_b++;
            if (qb.size() == 0) chk("b_unexpected_valid", b_if.valid, 0);
            else chk("b_read_data", b_if.out, qb.pop_front());
        end else begin
            run_b = 0;
        end
    endtask

    task automatic idle_a();
        a_if.e = 1'b0; a_if.w = 1'b0; a_if.r = 1'b0;
    endtask

    task automatic wr_a(input int addr, input logic [15:0] data);
        a_if.e = 1'b1; a_if.w = 1'b1; a_if.r = 1'b0;
        a_if.addr = 6'(addr); a_if.d = data;
        tick();
    endtask

    task automatic rd_a(input int addr, input logic [15:0] exp);
        a_if.e = 1'b1; a_if.w = 1'b0; a_if.r = 1'b1;
        a_if.addr = 6'(addr);
        qa.push_back(exp);
        tick();
    endtask

    // Count cycles with BUSY high starting from the current (release) cycle.
    task automatic count_busy_a(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (a_if.busy !== 1'b1) break;
            n++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_a();
        a_if.addr = '0; a_if.d = '0;
        b_if.e = 1'b0; b_if.w = 1'b0; b_if.r = 1'b0;
        b_if.addr = '0; b_if.d = '0;
        tick();
        tick();

        // Reset state.
        chk("rst_out", a_if.out, 0);
        chk("rst_valid", a_if.valid, 0);
        chk("rst_busy", a_if.busy, 1);
        chk("rst_busy_b", b_if.busy, 1);

        // Sweep with E=W=R=1 held: strobes must be ignored, BUSY high 64 cycles.
        a_if.e = 1'b1; a_if.w = 1'b1; a_if.r = 1'b1; a_if.d = 16'hFFFF;
        a_if.addr = 6'($urandom_range(0, 63));
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (a_if.busy !== 1'b1) break;
            cnt++;
            a_if.addr = 6'($urandom_range(0, 63));
            tick();
        end
        idle_a();
        chk("sweep_busy_cycles", cnt, 64);
        chk("sweep_end_valid", a_if.valid, 0);
        for (int i = 0; i < 64; i++) rd_a(i, 16'h0000);
        idle_a();
        chk("clear_burst_run", run_a, 64);
        chk("clear_queue_drained", qa.size(), 0);
        tick();
        chk("no_read_valid", a_if.valid, 0);
        chk("no_read_hold", a_if.out, 0);

        // Write i to address i, read all back as one back-to-back burst.
        for (int i = 0; i < 64; i++) wr_a(i, 16'(i));
        for (int i = 0; i < 64; i++) rd_a(i, 16'(i));
        idle_a();
        chk("burst_run", run_a, 64);
        chk("burst_queue_drained", qa.size(), 0);

        // Same-address read and write in one cycle.
`ifdef RAM_PARAM_FWD_EN
        collide_exp = 16'hABCD;
`else
        collide_exp = 16'h1111;
`endif
        wr_a(5, 16'h1111);
        a_if.e = 1'b1; a_if.w = 1'b1; a_if.r = 1'b1;
        a_if.addr = 6'd5; a_if.d = 16'hABCD;
        qa.push_back(collide_exp);
        tick();
        rd_a(5, 16'hABCD);
        idle_a();
        tick();
        chk("collide_drained", qa.size(), 0);

        // E=0 blocks both strobes: no write, no VALID, OUT holds.
        rd_a(9, 16'd9);
        a_if.e = 1'b0; a_if.w = 1'b1; a_if.r = 1'b1;
        a_if.addr = 6'd9; a_if.d = 16'hFFFF;
        tick();
        chk("e0_valid", a_if.valid, 0);
        chk("e0_out_hold", a_if.out, 16'd9);
        tick();
        chk("e0_out_hold2", a_if.out, 16'd9);
        rd_a(9, 16'd9);

        // Asynchronous reset mid-read: outputs clear at once, no clock edge.
        rst = 1'b1;
        #1;
        chk("async_rst_out", a_if.out, 0);
        chk("async_rst_valid", a_if.valid, 0);
        chk("async_rst_busy", a_if.busy, 1);
        idle_a();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        chk("mid_sweep_busy", a_if.busy, 1);
        // Sweep pointer is at address 30 here; restart it.
        rst = 1'b1;
        #1;
        chk("restart_busy", a_if.busy, 1);
        tick();
        rst = 1'b0;
        count_busy_a(cnt);
        chk("restart_busy_cycles", cnt, 64);
        for (int i = 0; i < 64; i++) rd_a(i, 16'h0000);
        idle_a();
        chk("restart_burst_run", run_a, 64);
        chk("restart_queue_drained", qa.size(), 0);

        // Wide-depth, narrow-width instance: full address range, same latency.
        for (int k = 0; k < 400; k++) begin
            if (b_if.busy !== 1'b1) break;
            tick();
        end
        chk("b_sweep_done", b_if.busy, 0);
        for (int i = 0; i < 256; i++) begin
            b_if.e = 1'b1; b_if.w = 1'b1; b_if.r = 1'b0;
            b_if.addr = 8'(i); b_if.d = 8'(i);
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            b_if.e = 1'b1; b_if.w = 1'b0; b_if.r = 1'b1;
            b_if.addr = 8'(i);
            qb.push_back(8'(i));
            tick();
        end
        b_if.e = 1'b0; b_if.r = 1'b0;
        chk("b_burst_run", run_b, 256);
        chk("b_queue_drained", qb.size(), 0);
        tick();
        chk("b_idle_valid", b_if.valid, 0);
        chk("b_out_hold", b_if.out, 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
